// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus a 1-bit-per-cycle multiply/divide sequencer.
// Multi-cycle ops stall the front end through MDBusy until their result is registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MD_IDLE | no MD op in flight; a valid MD op from ID starts the sequencer
// MD_RUN  | one shift-add / restoring-subtract step per cycle, cnt counts down
// MD_DONE | sign-corrected result feeds the EX register; waits out Stall
module ex_stage_md #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              IntDetect,
    input  logic              IDEn,
    input  logic [ADDR_W-1:0] IDPC,
    input  logic [3:0]        IDALUOp,
    input  logic [DATA_W-1:0] IDALUIn0,
    input  logic [DATA_W-1:0] IDALUIn1,
    input  logic [REG_W-1:0]  IDDstAddr,
    input  logic              IDGPRWE_,
    input  logic [1:0]        IDMemOp,
    input  logic [DATA_W-1:0] IDMemWrData,
    output logic              MDBusy,
    output logic [ADDR_W-1:0] EXPC,
    output logic              EXEn,
    output logic [DATA_W-1:0] EXOut,
    output logic              EXOF,
    output logic [REG_W-1:0]  EXDstAddr,
    output logic              EXGPRWE_,
    output logic [1:0]        EXMemOp,
    output logic [DATA_W-1:0] EXMemWrData
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHRL = 4'd6;
    localparam logic [3:0] OP_SHLL = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_MULH = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REM  = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

    md_state_t         state, state_nx;
    logic [5:0]        cnt;
    logic [3:0]        md_op;
    logic [DATA_W-1:0] acc, lo, opb;
    logic              neg_res;

    logic              kill, is_md, start, md_is_mul;
    logic              sgn_op, sa, sb, dz;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   mul_sum, div_shift, div_diff;
    logic [DATA_W-1:0] md_res, alu_res, add_res, sub_res;
    logic              alu_of;

    assign kill  = Flush | IntDetect;
    assign is_md = (IDALUOp >= OP_MUL) && (IDALUOp <= OP_REMU);
    assign start = (state == MD_IDLE) && IDEn && is_md && !kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        MDBusy   = 1'b0;
        unique case (state)
            MD_IDLE: begin
                MDBusy = start;
                if (start) state_nx = MD_RUN;
            end
            MD_RUN: begin
                MDBusy = 1'b1;
                if (cnt == 6'd0) state_nx = MD_DONE;
            end
            MD_DONE: begin
                if (!Stall) state_nx = MD_IDLE;
            end
            default: state_nx = MD_IDLE;
        endcase
        if (kill) state_nx = MD_IDLE;
    end

    // Operands are reduced to magnitudes up front; sign is restored in DONE
    assign sgn_op = (IDALUOp == OP_MULH) || (IDALUOp == OP_DIV) || (IDALUOp == OP_REM);
    assign sa     = sgn_op & IDALUIn0[DATA_W-1];
    assign sb     = sgn_op & IDALUIn1[DATA_W-1];
    assign abs_a  = sa ? -IDALUIn0 : IDALUIn0;
    assign abs_b  = sb ? -IDALUIn1 : IDALUIn1;
    assign dz     = (IDALUIn1 == '0);

    assign md_is_mul = (md_op == OP_MUL) || (md_op == OP_MULH);
    assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opb} : {(DATA_W+1){1'b0}});
    assign div_shift = {acc, lo[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 6'd0;
            md_op   <= OP_PASS;
            acc     <= '0;
            lo      <= '0;
            opb     <= '0;
            neg_res <= 1'b0;
        end else if (kill) begin
            cnt <= 6'd0;
        end else if (start) begin
            cnt   <= 6'(DATA_W - 1);
            md_op <= IDALUOp;
            acc   <= '0;
            lo    <= abs_a;
            opb   <= abs_b;
            unique case (IDALUOp)
                OP_MULH: neg_res <= sa ^ sb;
                OP_DIV:  neg_res <= (sa ^ sb) & ~dz;   // x/0 stays all ones
                OP_REM:  neg_res <= sa;
                default: neg_res <= 1'b0;
            endcase
        end else if (state == MD_RUN) begin
            if (cnt != 6'd0) cnt <= cnt - 6'd1;
            if (md_is_mul) begin
                acc <= mul_sum[DATA_W:1];
                lo  <= {mul_sum[0], lo[DATA_W-1:1]};
            end else if (!div_diff[DATA_W]) begin
                acc <= div_diff[DATA_W-1:0];
                lo  <= {lo[DATA_W-2:0], 1'b1};
            end else begin
                acc <= div_shift[DATA_W-1:0];
                lo  <= {lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // High half of -{acc,lo}: the +1 only carries into acc when lo is zero
    always_comb begin
        md_res = lo;
        unique case (md_op)
            OP_MUL:           md_res = lo;
            OP_MULH:          md_res = neg_res ? (~acc + DATA_W'(lo == '0)) : acc;
            OP_DIV, OP_DIVU:  md_res = neg_res ? -lo : lo;
            OP_REM, OP_REMU:  md_res = neg_res ? -acc : acc;
            default:          md_res = lo;
        endcase
    end

    assign add_res = IDALUIn0 + IDALUIn1;
    assign sub_res = IDALUIn0 - IDALUIn1;

    always_comb begin
        alu_res = IDALUIn0;
        alu_of  = 1'b0;
        unique case (IDALUOp)
            OP_ADD: begin
                alu_res = add_res;
                alu_of  = (IDALUIn0[DATA_W-1] == IDALUIn1[DATA_W-1]) &&
                          (add_res[DATA_W-1] != IDALUIn0[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_of  = (IDALUIn0[DATA_W-1] != IDALUIn1[DATA_W-1]) &&
                          (sub_res[DATA_W-1] != IDALUIn0[DATA_W-1]);
            end
            OP_AND:  alu_res = IDALUIn0 & IDALUIn1;
            OP_OR:   alu_res = IDALUIn0 | IDALUIn1;
            OP_XOR:  alu_res = IDALUIn0 ^ IDALUIn1;
            OP_SHRL: alu_res = IDALUIn0 >> IDALUIn1[SH_W-1:0];
            OP_SHLL: alu_res = IDALUIn0 << IDALUIn1[SH_W-1:0];
            default: alu_res = IDALUIn0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EXPC        <= '0;
            EXEn        <= 1'b0;
            EXOut       <= '0;
            EXOF        <= 1'b0;
            EXDstAddr   <= '0;
            EXGPRWE_    <= 1'b1;
            EXMemOp     <= 2'd0;
            EXMemWrData <= '0;
        end else if (kill || (!Stall && MDBusy)) begin
            EXPC        <= '0;
            EXEn        <= 1'b0;
            EXOut       <= '0;
            EXOF        <= 1'b0;
            EXDstAddr   <= '0;
            EXGPRWE_    <= 1'b1;
            EXMemOp     <= 2'd0;
            EXMemWrData <= '0;
        end else if (!Stall) begin
            EXPC        <= IDPC;
            EXEn        <= IDEn;
            EXDstAddr   <= IDDstAddr;
            EXMemOp     <= IDMemOp;
            EXMemWrData <= IDMemWrData;
            if (state == MD_DONE) begin
                EXOut    <= md_res;
                EXOF     <= 1'b0;
                EXGPRWE_ <= IDGPRWE_;
            end else begin
                EXOut    <= alu_res;
                EXOF     <= alu_of;
                EXGPRWE_ <= IDGPRWE_ | alu_of;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU ops, MD corner cases, flush, stall at DONE, reset mid-run.
module tb_ex_stage_md;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset, Stall, Flush, IntDetect, IDEn, IDGPRWE_;
    logic [ADDR_W-1:0] IDPC;
    logic [3:0]        IDALUOp;
    logic [DATA_W-1:0] IDALUIn0, IDALUIn1, IDMemWrData;
    logic [REG_W-1:0]  IDDstAddr;
    logic [1:0]        IDMemOp;
    logic              MDBusy, EXEn, EXOF, EXGPRWE_;
    logic [ADDR_W-1:0] EXPC;
    logic [DATA_W-1:0] EXOut, EXMemWrData;
    logic [REG_W-1:0]  EXDstAddr;
    logic [1:0]        EXMemOp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .IntDetect(IntDetect),
        .IDEn(IDEn), .IDPC(IDPC), .IDALUOp(IDALUOp), .IDALUIn0(IDALUIn0),
        .IDALUIn1(IDALUIn1), .IDDstAddr(IDDstAddr), .IDGPRWE_(IDGPRWE_),
        .IDMemOp(IDMemOp), .IDMemWrData(IDMemWrData), .MDBusy(MDBusy),
        .EXPC(EXPC), .EXEn(EXEn), .EXOut(EXOut), .EXOF(EXOF), .EXDstAddr(EXDstAddr),
        .EXGPRWE_(EXGPRWE_), .EXMemOp(EXMemOp), .EXMemWrData(EXMemWrData)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic of);
        IDEn = 1'b1; IDALUOp = op; IDALUIn0 = a; IDALUIn1 = b; IDGPRWE_ = 1'b0;
        @(negedge clk);
        chk({tag, "_busy"}, MDBusy, 0);
        @(posedge clk); #1;
        chk(tag, EXOut, exp);
        chk({tag, "_of"}, EXOF, of);
        chk({tag, "_we"}, EXGPRWE_, of);
    endtask

    task automatic md(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        int n;
        n = 0;
        IDEn = 1'b1; IDALUOp = op; IDALUIn0 = a; IDALUIn1 = b; IDGPRWE_ = 1'b0;
        @(negedge clk);
        while (MDBusy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy"}, n, DATA_W + 1);
        chk({tag, "_bubble"}, EXEn, 0);
        @(posedge clk); #1;
        chk(tag, EXOut, exp);
        chk({tag, "_en"}, EXEn, 1);
        chk({tag, "_of"}, EXOF, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; Stall = 1'b0; Flush = 1'b0; IntDetect = 1'b0;
        IDEn = 1'b0; IDPC = '0; IDALUOp = 4'd0; IDALUIn0 = '0; IDALUIn1 = '0;
        IDDstAddr = '0; IDGPRWE_ = 1'b1; IDMemOp = 2'd0; IDMemWrData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", EXOut, 0);
        chk("rst_we", EXGPRWE_, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", MDBusy, 0);
        chk("rst_en", EXEn, 0);
        chk("rst_of", EXOF, 0);
        @(posedge clk); #1;

        IDPC = 30'h1234567; IDDstAddr = 5'h1A; IDMemOp = 2'd2; IDMemWrData = 32'hDEADBEEF;
        alu("pass", 4'd0, 32'h12345678, 32'h0, 32'h12345678, 1'b0);
        chk("pc", EXPC, 30'h1234567);
        chk("dst", EXDstAddr, 5'h1A);
        chk("memop", EXMemOp, 2'd2);
        chk("wrdata", EXMemWrData, 32'hDEADBEEF);
        chk("en", EXEn, 1);
        IDMemOp = 2'd0;

        alu("add_of",   4'd1, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
        alu("add_of2",  4'd1, 32'h80000000, 32'h80000000, 32'h0,        1'b1);
        alu("add",      4'd1, 32'h5,        32'hFFFFFFFF, 32'h4,        1'b0);
        alu("sub",      4'd2, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0);
        alu("sub_of",   4'd2, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1);
        alu("and",      4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0);
        alu("or",       4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0);
        alu("xor",      4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
        alu("shrl",     4'd6, 32'h80000001, 32'h24,       32'h08000000, 1'b0);
        alu("shll",     4'd7, 32'h80000001, 32'h21,       32'h00000002, 1'b0);
        alu("op15",     4'd15, 32'hCAFEBABE, 32'h1,       32'hCAFEBABE, 1'b0);

        // MD ops chained back-to-back
        md("mulh",      4'd9,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF);
        md("mul",       4'd8,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA);
        md("mulh_mn",   4'd9,  32'h80000000, 32'h80000000, 32'h40000000);
        md("mulh_mx",   4'd9,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF);
        md("div_ovf",   4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        md("rem_ovf",   4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h0);
        md("rem_neg",   4'd12, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
        md("div_neg",   4'd10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD);
        md("div_negb",  4'd10, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD);
        md("rem_negb",  4'd12, 32'h7,        32'hFFFFFFFE, 32'h1);
        md("divu_z",    4'd11, 32'h5,        32'h0,        32'hFFFFFFFF);
        md("remu_z",    4'd13, 32'h5,        32'h0,        32'h5);
        md("div_z",     4'd10, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF);
        md("rem_z",     4'd12, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB);
        md("divu",      4'd11, 32'd100,      32'd7,        32'd14);
        md("remu",      4'd13, 32'd100,      32'd7,        32'd2);

        // Flush at cycle 10 of a DIVU
        IDEn = 1'b1; IDALUOp = 4'd11; IDALUIn0 = 32'd100; IDALUIn1 = 32'd7;
        repeat (10) begin
            @(posedge clk); #1;
        end
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_c10", MDBusy, 1);
        @(posedge clk); #1;
        Flush = 1'b0; IDEn = 1'b0;
        chk("flush_en", EXEn, 0);
        chk("flush_we", EXGPRWE_, 1);
        @(negedge clk);
        chk("flush_busy_c11", MDBusy, 0);
        @(posedge clk); #1;
        alu("post_flush_add", 4'd1, 32'd3, 32'd4, 32'd7, 1'b0);

        // Stall held over cycles 30..40 of MUL 6 x 7
        IDEn = 1'b1; IDALUOp = 4'd8; IDALUIn0 = 32'd6; IDALUIn1 = 32'd7;
        n = 0;
        for (int c = 0; c < 42; c++) begin
            if (c == 30) Stall = 1'b1;
            if (c == 41) Stall = 1'b0;
            @(negedge clk);
            if (MDBusy) n++;
            if (c == 40) chk("stall_hold_en", EXEn, 0);
            @(posedge clk); #1;
        end
        chk("stall_busy", n, DATA_W + 1);
        chk("stall_out", EXOut, 42);
        chk("stall_en", EXEn, 1);
        IDEn = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while a MUL runs and EX is held by Stall
        alu("pre_rst_add", 4'd1, 32'd10, 32'd20, 32'd30, 1'b0);
        Stall = 1'b1; IDALUOp = 4'd8; IDALUIn0 = 32'd9; IDALUIn1 = 32'd9;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("stall_hold_out", EXOut, 30);
        #2;
        reset = 1'b1; IDEn = 1'b0; Stall = 1'b0;
        #1;
        chk("arst_out", EXOut, 0);
        chk("arst_en", EXEn, 0);
        chk("arst_we", EXGPRWE_, 1);
        chk("arst_pc", EXPC, 0);
        chk("arst_busy", MDBusy, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", MDBusy, 0);
        @(posedge clk); #1;
        chk("post_rst_en", EXEn, 0);
        md("mul_after_rst", 4'd8, 32'd9, 32'd9, 32'd81);
        IDEn = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with an integrated iterative multiply/divide unit. It sits between the decode stage and the memory stage. Single-cycle ALU operations complete in one cycle as before. MUL/MULH/DIV/DIVU/REM/REMU run on a 1-bit-per-cycle sequencer that raises `MDBusy` to stall the front of the pipeline until the result is registered. Width is generic, and the EX pipeline register supports stall, flush and interrupt bubbles.

## Interface
Parameters:
- `DATA_W`, 32: data path width; must be ≥ 8 and even.
- `ADDR_W`, 30: word-address (PC) width.
- `REG_W`, 5: register-file address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Stall` in 1: hold the EX register.
- `Flush` in 1: kill the current EX/MD operation.
- `IntDetect` in 1: interrupt taken; same effect as `Flush`.
- `IDEn` in 1: ID output valid.
- `IDPC` in `ADDR_W`: PC of the instruction.
- `IDALUOp` in 4: operation code (see Operation).
- `IDALUIn0` in `DATA_W`: operand A.
- `IDALUIn1` in `DATA_W`: operand B.
- `IDDstAddr` in `REG_W`: destination register.
- `IDGPRWE_` in 1: register write enable, active-low.
- `IDMemOp` in 2: memory op; 0 means none.
- `IDMemWrData` in `DATA_W`: store data.
- `MDBusy` out 1: combinational stall request to the PC/IF/ID stages.
- `EXPC` out `ADDR_W`: registered copy of `IDPC`.
- `EXEn` out 1: registered copy of `IDEn`.
- `EXOut` out `DATA_W`: registered result.
- `EXOF` out 1: registered signed overflow flag.
- `EXDstAddr` out `REG_W`: registered copy of `IDDstAddr`.
- `EXGPRWE_` out 1: registered copy of `IDGPRWE_`.
- `EXMemOp` out 2: registered copy of `IDMemOp`.
- `EXMemWrData` out `DATA_W`: registered copy of `IDMemWrData`.

## Operation
- **Op codes:**
  - 0 PASS: output `In0`.
  - 1 ADD.
  - 2 SUB.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHRL, shift amount `In1[log2(DATA_W)-1:0]`.
  - 7 SHLL, same shift amount.
  - 8 MUL: low `DATA_W` bits of the product.
  - 9 MULH: signed × signed, high `DATA_W` bits.
  - 10 DIV, signed.
  - 11 DIVU.
  - 12 REM, signed.
  - 13 REMU.
  - 14–15: behave as PASS.
- **Overflow:** ADD/SUB signed overflow sets `EXOF`=1 and forces `EXGPRWE_`=1 (write suppressed). All other ops produce `EXOF`=0.
- **MD sequencer states:** IDLE, RUN, DONE; 6-bit down-counter `cnt`.
  - IDLE: when `IDEn` & MD op & ~`Flush` & ~`IntDetect`:
    - capture operand magnitudes and result-sign flags;
    - set `cnt`=`DATA_W`-1;
    - go to RUN.
  - RUN: one shift-add step (MUL) or one restoring-subtract step (DIV) per cycle. When `cnt`=0, go to DONE; otherwise decrement `cnt`.
  - DONE: apply sign correction; result drives the EX register input. When ~`Stall`, go to IDLE; otherwise hold DONE.
  - `Flush`/`IntDetect` in any state forces IDLE next cycle.
- **`MDBusy`** = (IDLE & MD op & `IDEn` & ~`Flush` & ~`IntDetect`) | RUN.
- **Divide by zero:**
  - DIV/DIVU quotient = all ones.
  - REM/REMU = dividend.
  - Iteration count is unchanged.
- **Signed overflow divide** (DIV with most-negative ÷ −1):
  - quotient = most-negative;
  - REM = 0;
  - `EXOF`=0.
- **Remainder sign** follows the dividend; **quotient sign** = XOR of the operand signs.
- **EX register update priority:**
  1. `reset`.
  2. `Flush`|`IntDetect`: load a bubble.
  3. `Stall`: hold all outputs.
  4. `MDBusy`: load a bubble.
  5. Otherwise: load the ID fields and the result.
- **Bubble:** `EXEn`=0, `EXGPRWE_`=1, `EXMemOp`=0, `EXOF`=0. `EXPC`, `EXOut` and `EXDstAddr` are don't-care; they are set to 0.

## Timing
- **Reset values:**
  - all `EX*` outputs 0, except `EXGPRWE_`=1;
  - sequencer in IDLE with `cnt`=0;
  - `MDBusy`=0 once `reset` is deasserted and no MD op is present.
- **Single-cycle ops:** operands at cycle n; `EXOut` valid at cycle n+1.
- **MD ops:** presented at cycle 0.
  - `MDBusy`=1 for cycles 0..`DATA_W` (`DATA_W`+1 cycles).
  - DONE occurs in cycle `DATA_W`+1, with `MDBusy`=0.
  - `EXOut` is valid from cycle `DATA_W`+2.
- **ID inputs while busy:** ID inputs must stay stable while `MDBusy`=1. Operands are captured at the cycle-0 edge; later changes are ignored until DONE.
- **`Stall` during RUN:** iteration continues. Only the DONE→IDLE transition and the EX load wait for `Stall` to drop.
- **Back-to-back MD ops:** the second op starts in the cycle after DONE, with no extra idle cycle.
- **`reset` mid-RUN:** immediate return to IDLE; no partial result is ever registered.

## Test plan
1. **Single-cycle ADD overflow:** ADD 0x7FFFFFFF + 1, `IDGPRWE_`=0 -> next cycle `EXOut`=0x80000000, `EXOF`=1, `EXGPRWE_`=1.
2. **Signed MULH:** MULH 0xFFFFFFFE × 0x00000003 -> `MDBusy` high exactly 33 cycles; `EXOut`=0xFFFFFFFF at cycle 34; MUL with the same operands gives 0xFFFFFFFA.
3. **Divide corner cases:**
   - DIV 0x80000000 ÷ 0xFFFFFFFF -> 0x80000000, `EXOF`=0.
   - REM −7 ÷ 2 -> 0xFFFFFFFF.
   - DIVU 5 ÷ 0 -> 0xFFFFFFFF.
   - REMU 5 ÷ 0 -> 5.
4. **Flush mid-run:** `Flush` pulsed at cycle 10 of a DIVU -> bubble registered (`EXEn`=0, `EXGPRWE_`=1); `MDBusy`=0 from cycle 11; a following ADD completes normally.
5. **Stall at DONE:** `Stall` held from cycle 30 to 40 during MUL 6 × 7 -> `EX*` held; `EXOut`=42 one cycle after `Stall` drops; `MDBusy` never reasserts.
6. **Reset mid-operation:** `reset` asserted during RUN -> all outputs at reset values asynchronously; after release, `MDBusy`=0 with `IDEn`=0.
